lsu_violation_ctrl: RTL and testbench

Sequences memory-ordering recovery for the Falco core. It collects store-set and device violations reported by the load pipes and selects the oldest one by ROB age. It then runs a fixed recovery sequence: ROB flush handshake, one-cycle IF redirect, one-cycle ID store-set training pulse. It sits between the LSU stage and the ROB/IF/ID consumers and replaces direct LSU-to-consumer violation wiring.

---
 rtl/lsu_violation_ctrl_pkg.sv | 41 ++++
 rtl/lsu_violation_ctrl_age_select.sv | 42 ++++
 rtl/lsu_violation_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_lsu_violation_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_violation_ctrl_pkg.sv
// Shared types for the LSU memory-ordering violation controller.
// The violation record is a packed struct, so its rob_tag field has a fixed width.
// ROB_TAG_W_DEF sets that width. The controller's ROB_TAG_W must keep this value.
package lsu_violation_ctrl_pkg;

    localparam int ROB_TAG_W_DEF = 5;
    localparam int PC_W          = 32;
    localparam int BHSR_W        = 16;
    localparam int SSIT_WIDTH    = 10;
    localparam int LFST_WIDTH    = 7;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [BHSR_W-1:0] BHSR_t;

    typedef struct packed {
        logic                     is_device;
        logic [ROB_TAG_W_DEF-1:0] rob_tag;
        pc_t                      pc;
        BHSR_t                    bhsr;
        logic [SSIT_WIDTH-1:0]    load_pc;
        logic [SSIT_WIDTH-1:0]    store_pc;
        logic [LFST_WIDTH-1:0]    load_id;
        logic [LFST_WIDTH-1:0]    store_id;
    } viol_info_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_TRAIN
    } viol_state_e;

    // Age relative to the ROB head. The subtraction wraps naturally. A smaller value is older.
    function automatic logic [ROB_TAG_W_DEF-1:0] rob_age(
        input logic [ROB_TAG_W_DEF-1:0] tag,
        input logic [ROB_TAG_W_DEF-1:0] head
    );
        return tag - head;
    endfunction

endpackage

// File: rtl/lsu_violation_ctrl_age_select.sv
// viol_age_select: combinational oldest-of-N picker over violation records.
// On equal age, the lowest index wins.
// The same picker serves two purposes:
//   - choosing among the load pipes;
//   - comparing an incumbent (index 0) against a challenger (index 1),
//     where the challenger wins only if it is strictly older.
module viol_age_select
    import lsu_violation_ctrl_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]             valid_i,
    input  viol_info_t [N-1:0]       info_i,
    input  logic [ROB_TAG_W_DEF-1:0] head_i,
    output logic                     sel_valid_o,
    output logic [IDX_W-1:0]         sel_idx_o,
    output viol_info_t               sel_info_o
);

    logic [ROB_TAG_W_DEF-1:0] best_age;
    logic [ROB_TAG_W_DEF-1:0] cur_age;

    // Linear scan. A later entry replaces the current best only when it is strictly older.
    always_comb begin
        sel_valid_o = 1'b0;
        sel_idx_o   = '0;
        sel_info_o  = '0;
        best_age    = '0;
        cur_age     = '0;
        for (int i = 0; i < N; i++) begin
            cur_age = rob_age(info_i[i].rob_tag, head_i);
            if (valid_i[i] && (!sel_valid_o || (cur_age < best_age))) begin
                sel_valid_o = 1'b1;
                sel_idx_o   = IDX_W'(i);
                sel_info_o  = info_i[i];
                best_age    = cur_age;
            end
        end
    end

endmodule

// File: rtl/lsu_violation_ctrl.sv
// lsu_violation_ctrl: collects store-set and device ordering violations from the load pipes.
// It runs one recovery at a time: ROB flush handshake, then an IF redirect pulse,
// then an ID store-set training pulse.
// A single pending slot keeps the oldest violation that arrives mid-sequence
// and is older than the one in progress.
// Optional macro FALCO_VIOLATION_STATS_EN adds two saturating completion counters.
module lsu_violation_ctrl
    import lsu_violation_ctrl_pkg::*;
#(
    parameter int N_PORTS   = 2,
    parameter int ROB_TAG_W = ROB_TAG_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PORTS-1:0]     viol_valid,
    input  viol_info_t [N_PORTS-1:0] viol_info,
    input  logic [ROB_TAG_W-1:0]   rob_head_tag,
    input  logic                   ext_flush,
    input  logic [ROB_TAG_W-1:0]   ext_flush_tag,
    output logic                   rob_flush_valid,
    output logic [ROB_TAG_W-1:0]   rob_flush_tag,
    input  logic                   rob_flush_ready,
    output logic                   if_redirect_valid,
    output pc_t                    if_redirect_pc,
    output BHSR_t                  if_redirect_bhsr,
    output logic                   id_train_valid,
    output logic                   id_train_device,
    output logic [SSIT_WIDTH-1:0]  id_train_load_pc,
    output logic [SSIT_WIDTH-1:0]  id_train_store_pc,
    output logic [LFST_WIDTH-1:0]  id_train_load_id,
    output logic [LFST_WIDTH-1:0]  id_train_store_id,
    output logic                   busy
`ifdef FALCO_VIOLATION_STATS_EN
    ,
    output logic [31:0]            stat_storeset_cnt,
    output logic [31:0]            stat_device_cnt
`endif
);

    viol_state_e state_q, state_d;
    viol_info_t  held_q, held_d;
    viol_info_t  pend_q, pend_d;
    logic        pend_valid_q, pend_valid_d;

    logic                  rob_flush_valid_q;
    logic [ROB_TAG_W-1:0]  rob_flush_tag_q;
    logic                  if_redirect_valid_q;
    pc_t                   if_redirect_pc_q;
    BHSR_t                 if_redirect_bhsr_q;
    logic                  id_train_valid_q;
    logic                  id_train_device_q;
    logic [SSIT_WIDTH-1:0] id_train_load_pc_q;
    logic [SSIT_WIDTH-1:0] id_train_store_pc_q;
    logic [LFST_WIDTH-1:0] id_train_load_id_q;
    logic [LFST_WIDTH-1:0] id_train_store_id_q;
    logic                  busy_q;

    logic [ROB_TAG_W_DEF-1:0] eft_age;
    logic [N_PORTS-1:0]       port_keep;
    logic                     held_live;
    logic                     held_kill;
    logic                     pend_keep;

    logic       inc_valid;
    viol_info_t inc_info;
    logic [((N_PORTS > 1) ? $clog2(N_PORTS) : 1)-1:0] inc_idx_unused;

    logic       hc_valid_unused;
    logic       hc_idx;
    viol_info_t hc_info_unused;
    logic       inc_acc;

    logic       pend_new_valid;
    logic       pc_idx_unused;
    viol_info_t pend_new_info;

    // An ext_flush squashes every entry whose age is at or above the age of the flush tag.
    assign eft_age   = rob_age(ext_flush_tag, rob_head_tag);
    assign held_live = (state_q != S_IDLE);
    assign held_kill = held_live && ext_flush &&
                       (rob_age(held_q.rob_tag, rob_head_tag) >= eft_age);
    assign pend_keep = pend_valid_q &&
                       !(ext_flush && (rob_age(pend_q.rob_tag, rob_head_tag) >= eft_age));

    // Incoming violations that a same-cycle ext_flush squashes are never captured.
    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port_filter
            assign port_keep[gi] = viol_valid[gi] &&
                !(ext_flush && (rob_age(viol_info[gi].rob_tag, rob_head_tag) >= eft_age));
        end
    endgenerate

    viol_age_select #(.N(N_PORTS)) u_sel_in (
        .valid_i     (port_keep),
        .info_i      (viol_info),
        .head_i      (rob_head_tag),
        .sel_valid_o (inc_valid),
        .sel_idx_o   (inc_idx_unused),
        .sel_info_o  (inc_info)
    );

    // The held record is the incumbent. The incoming record counts only if it is strictly older.
    // The comparison uses the held record even in a cycle where ext_flush kills it.
    // An incoming record that survived the flush filter is always older than the killed one,
    // so it is kept for the pending slot.
    viol_age_select #(.N(2)) u_sel_held (
        .valid_i     ({inc_valid, held_live}),
        .info_i      ({inc_info, held_q}),
        .head_i      (rob_head_tag),
        .sel_valid_o (hc_valid_unused),
        .sel_idx_o   (hc_idx),
        .sel_info_o  (hc_info_unused)
    );

    assign inc_acc = held_live && inc_valid && hc_idx;

    // The pending slot is replaced only by a strictly older record.
    viol_age_select #(.N(2)) u_sel_pend (
        .valid_i     ({inc_acc, pend_keep}),
        .info_i      ({inc_info, pend_q}),
        .head_i      (rob_head_tag),
        .sel_valid_o (pend_new_valid),
        .sel_idx_o   (pc_idx_unused),
        .sel_info_o  (pend_new_info)
    );

    // Next-state decision.
    // Finishing TRAIN and losing the held record to ext_flush both promote the pending slot.
    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        pend_valid_d = pend_new_valid;
        pend_d       = pend_new_info;
        case (state_q)
            S_IDLE: begin
                pend_valid_d = 1'b0;
                pend_d       = '0;
                if (inc_valid) begin
                    held_d  = inc_info;
                    state_d = S_FLUSH;
                end
            end
            default: begin
                if (held_kill || (state_q == S_TRAIN)) begin
                    pend_valid_d = 1'b0;
                    pend_d       = '0;
                    if (pend_new_valid) begin
                        held_d  = pend_new_info;
                        state_d = S_FLUSH;
                    end else begin
                        held_d  = '0;
                        state_d = S_IDLE;
                    end
                end else if (state_q == S_FLUSH) begin
                    if (rob_flush_ready) begin
                        state_d = S_REDIRECT;
                    end
                end else begin
                    state_d = S_TRAIN;
                end
            end
        endcase
    end

    // State plus registered outputs.
    // Each output is loaded from the next state, and data fields are zero unless their valid is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= S_IDLE;
            held_q              <= '0;
            pend_q              <= '0;
            pend_valid_q        <= 1'b0;
            rob_flush_valid_q   <= 1'b0;
            rob_flush_tag_q     <= '0;
            if_redirect_valid_q <= 1'b0;
            if_redirect_pc_q    <= '0;
            if_redirect_bhsr_q  <= '0;
            id_train_valid_q    <= 1'b0;
            id_train_device_q   <= 1'b0;
            id_train_load_pc_q  <= '0;
            id_train_store_pc_q <= '0;
            id_train_load_id_q  <= '0;
            id_train_store_id_q <= '0;
            busy_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            held_q              <= held_d;
            pend_q              <= pend_d;
            pend_valid_q        <= pend_valid_d;
            rob_flush_valid_q   <= (state_d == S_FLUSH);
            rob_flush_tag_q     <= (state_d == S_FLUSH) ? held_d.rob_tag : '0;
            if_redirect_valid_q <= (state_d == S_REDIRECT);
            if_redirect_pc_q    <= (state_d == S_REDIRECT) ? held_d.pc : '0;
            if_redirect_bhsr_q  <= (state_d == S_REDIRECT) ? held_d.bhsr : '0;
            id_train_valid_q    <= (state_d == S_TRAIN);
            id_train_device_q   <= (state_d == S_TRAIN) ? held_d.is_device : 1'b0;
            id_train_load_pc_q  <= (state_d == S_TRAIN) ? held_d.load_pc : '0;
            id_train_store_pc_q <= (state_d == S_TRAIN) ? held_d.store_pc : '0;
            id_train_load_id_q  <= (state_d == S_TRAIN) ? held_d.load_id : '0;
            id_train_store_id_q <= (state_d == S_TRAIN) ? held_d.store_id : '0;
            busy_q              <= (state_d != S_IDLE);
        end
    end

    assign rob_flush_valid   = rob_flush_valid_q;
    assign rob_flush_tag     = rob_flush_tag_q;
    assign if_redirect_valid = if_redirect_valid_q;
    assign if_redirect_pc    = if_redirect_pc_q;
    assign if_redirect_bhsr  = if_redirect_bhsr_q;
    assign id_train_valid    = id_train_valid_q;
    assign id_train_device   = id_train_device_q;
    assign id_train_load_pc  = id_train_load_pc_q;
    assign id_train_store_pc = id_train_store_pc_q;
    assign id_train_load_id  = id_train_load_id_q;
    assign id_train_store_id = id_train_store_id_q;
    assign busy              = busy_q;

`ifdef FALCO_VIOLATION_STATS_EN
    logic [31:0] stat_storeset_cnt_q;
    logic [31:0] stat_device_cnt_q;

    // Count each training pulse that was driven, split by violation kind. Both counters saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_storeset_cnt_q <= '0;
            stat_device_cnt_q   <= '0;
        end else if (id_train_valid_q) begin
            if (id_train_device_q) begin
                if (stat_device_cnt_q != '1) begin
                    stat_device_cnt_q <= stat_device_cnt_q + 32'd1;
                end
            end else begin
                if (stat_storeset_cnt_q != '1) begin
                    stat_storeset_cnt_q <= stat_storeset_cnt_q + 32'd1;
                end
            end
        end
    end

    assign stat_storeset_cnt = stat_storeset_cnt_q;
    assign stat_device_cnt   = stat_device_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_violation_ctrl.sv
// Testbench for lsu_violation_ctrl.
// A directed pass pins the model with literal expectations, then a randomized pass follows.
// A behavioural model is compared against the DUT on every falling clock edge.
// Define FALCO_VIOLATION_STATS_EN to also cover the statistics counters.
module tb_lsu_violation_ctrl;
    import lsu_violation_ctrl_pkg::*;

    localparam int NP = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NP-1:0]         viol_valid;
    viol_info_t [NP-1:0]   viol_info;
    logic [4:0]            rob_head_tag;
    logic                  ext_flush;
    logic [4:0]            ext_flush_tag;
    logic                  rob_flush_valid;
    logic [4:0]            rob_flush_tag;
    logic                  rob_flush_ready;
    logic                  if_redirect_valid;
    pc_t                   if_redirect_pc;
    BHSR_t                 if_redirect_bhsr;
    logic                  id_train_valid;
    logic                  id_train_device;
    logic [SSIT_WIDTH-1:0] id_train_load_pc;
    logic [SSIT_WIDTH-1:0] id_train_store_pc;
    logic [LFST_WIDTH-1:0] id_train_load_id;
    logic [LFST_WIDTH-1:0] id_train_store_id;
    logic                  busy;
`ifdef FALCO_VIOLATION_STATS_EN
    logic [31:0]           stat_storeset_cnt;
    logic [31:0]           stat_device_cnt;
`endif

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    lsu_violation_ctrl #(.N_PORTS(NP), .ROB_TAG_W(5)) dut (
        .clk               (clk),
        .rst               (rst),
        .viol_valid        (viol_valid),
        .viol_info         (viol_info),
        .rob_head_tag      (rob_head_tag),
        .ext_flush         (ext_flush),
        .ext_flush_tag     (ext_flush_tag),
        .rob_flush_valid   (rob_flush_valid),
        .rob_flush_tag     (rob_flush_tag),
        .rob_flush_ready   (rob_flush_ready),
        .if_redirect_valid (if_redirect_valid),
        .if_redirect_pc    (if_redirect_pc),
        .if_redirect_bhsr  (if_redirect_bhsr),
        .id_train_valid    (id_train_valid),
        .id_train_device   (id_train_device),
        .id_train_load_pc  (id_train_load_pc),
        .id_train_store_pc (id_train_store_pc),
        .id_train_load_id  (id_train_load_id),
        .id_train_store_id (id_train_store_id),
        .busy              (busy)
`ifdef FALCO_VIOLATION_STATS_EN
        ,
        .stat_storeset_cnt (stat_storeset_cnt),
        .stat_device_cnt   (stat_device_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_phase: 0 idle, 1 waiting for the ROB to accept the flush, 2 redirect, 3 train
    int         m_phase = 0;
    viol_info_t m_held  = '0;
    viol_info_t m_pend  = '0;
    bit         m_pend_v = 1'b0;
    logic [31:0] m_ss  = '0;
    logic [31:0] m_dev = '0;

    function automatic int agef(input logic [4:0] t, input logic [4:0] h);
        logic [4:0] d;
        d = t - h;
        return int'(d);
    endfunction

    always @(posedge clk) begin : model
        int         eage;
        bit         inc_v;
        viol_info_t inc;
        bit         hkill;
        bit         adv;
        if (rst) begin
            m_ss  = '0;
            m_dev = '0;
        end else if (m_phase == 3) begin
            if (m_held.is_device) begin
                if (m_dev != 32'hffff_ffff) m_dev = m_dev + 1;
            end else begin
                if (m_ss != 32'hffff_ffff) m_ss = m_ss + 1;
            end
        end
        if (rst) begin
            m_phase  = 0;
            m_pend_v = 1'b0;
        end else begin
            eage  = agef(ext_flush_tag, rob_head_tag);
            inc_v = 1'b0;
            inc   = '0;
            for (int p = 0; p < NP; p++) begin
                if (viol_valid[p] && !(ext_flush && agef(viol_info[p].rob_tag, rob_head_tag) >= eage)) begin
                    if (!inc_v || agef(viol_info[p].rob_tag, rob_head_tag) < agef(inc.rob_tag, rob_head_tag)) begin
                        inc   = viol_info[p];
                        inc_v = 1'b1;
                    end
                end
            end
            if (m_phase == 0) begin
                if (inc_v) begin
                    m_held  = inc;
                    m_phase = 1;
                end
            end else begin
                hkill = ext_flush && (agef(m_held.rob_tag, rob_head_tag) >= eage);
                if (m_pend_v && ext_flush && agef(m_pend.rob_tag, rob_head_tag) >= eage) m_pend_v = 1'b0;
                if (inc_v && agef(inc.rob_tag, rob_head_tag) < agef(m_held.rob_tag, rob_head_tag) &&
                    (!m_pend_v || agef(inc.rob_tag, rob_head_tag) < agef(m_pend.rob_tag, rob_head_tag))) begin
                    m_pend   = inc;
                    m_pend_v = 1'b1;
                end
                adv = hkill || (m_phase == 3);
                if (!hkill) begin
                    if (m_phase == 1 && rob_flush_ready) m_phase = 2;
                    else if (m_phase == 2) m_phase = 3;
                end
                if (adv) begin
                    if (m_pend_v) begin
                        m_held   = m_pend;
                        m_pend_v = 1'b0;
                        m_phase  = 1;
                    end else begin
                        m_phase = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        bit fv, rv, tv;
        fv = (m_phase == 1);
        rv = (m_phase == 2);
        tv = (m_phase == 3);
        chk("flush_valid", 64'(rob_flush_valid), 64'(fv));
        chk("flush_tag", 64'(rob_flush_tag), fv ? 64'(m_held.rob_tag) : 64'd0);
        chk("redir_valid", 64'(if_redirect_valid), 64'(rv));
        chk("redir_pc", 64'(if_redirect_pc), rv ? 64'(m_held.pc) : 64'd0);
        chk("redir_bhsr", 64'(if_redirect_bhsr), rv ? 64'(m_held.bhsr) : 64'd0);
        chk("train_valid", 64'(id_train_valid), 64'(tv));
        chk("train_dev", 64'(id_train_device), tv ? 64'(m_held.is_device) : 64'd0);
        chk("train_lpc", 64'(id_train_load_pc), tv ? 64'(m_held.load_pc) : 64'd0);
        chk("train_spc", 64'(id_train_store_pc), tv ? 64'(m_held.store_pc) : 64'd0);
        chk("train_lid", 64'(id_train_load_id), tv ? 64'(m_held.load_id) : 64'd0);
        chk("train_sid", 64'(id_train_store_id), tv ? 64'(m_held.store_id) : 64'd0);
        chk("busy", 64'(busy), 64'(m_phase != 0));
`ifdef FALCO_VIOLATION_STATS_EN
        chk("stat_ss", 64'(stat_storeset_cnt), 64'(m_ss));
        chk("stat_dev", 64'(stat_device_cnt), 64'(m_dev));
`endif
    end

    // ---------------- stimulus ----------------
    function automatic viol_info_t mk(input int tag, input bit dev);
        viol_info_t r;
        r.is_device = dev;
        r.rob_tag   = 5'(tag);
        r.pc        = 32'h8000_0000 + 32'(tag * 4);
        r.bhsr      = 16'h0100 + 16'(tag);
        r.load_pc   = 10'(tag);
        r.store_pc  = 10'(tag + 1);
        r.load_id   = 7'(tag);
        r.store_id  = 7'(tag + 2);
        return r;
    endfunction

    function automatic viol_info_t rmk();
        viol_info_t r;
        r.is_device = 1'($urandom_range(0, 1));
        r.rob_tag   = 5'($urandom_range(0, 31));
        r.pc        = $urandom();
        r.bhsr      = 16'($urandom());
        r.load_pc   = 10'($urandom());
        r.store_pc  = 10'($urandom());
        r.load_id   = 7'($urandom());
        r.store_id  = 7'($urandom());
        return r;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        viol_valid = '0;
        ext_flush  = 1'b0;
    endtask

    task automatic run_seq(input int tag, input bit dev);
        rob_flush_ready = 1'b1;
        viol_info[0]    = mk(tag, dev);
        viol_valid      = 2'b01;
        nxt();
        quiet();
        nxt();
        nxt();
        nxt();
    endtask

    initial begin
        rst             = 1'b1;
        viol_valid      = '0;
        viol_info       = '0;
        rob_head_tag    = '0;
        ext_flush       = 1'b0;
        ext_flush_tag   = '0;
        rob_flush_ready = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_flush_tag", 64'(rob_flush_tag), 64'd0);

        // single violation, ready held high
        rob_head_tag = 5'd0;
        rob_flush_ready = 1'b1;
        viol_info[0] = mk(5, 1'b0);
        viol_valid = 2'b01;
        nxt();
        quiet();
        chk("s1_flush_valid", 64'(rob_flush_valid), 64'd1);
        chk("s1_flush_tag", 64'(rob_flush_tag), 64'd5);
        nxt();
        chk("s1_redir_valid", 64'(if_redirect_valid), 64'd1);
        chk("s1_redir_pc", 64'(if_redirect_pc), 64'h8000_0014);
        nxt();
        chk("s1_train_valid", 64'(id_train_valid), 64'd1);
        nxt();
        chk("s1_busy_done", 64'(busy), 64'd0);

        // two ports in one cycle, wrapped ages
        rob_head_tag = 5'd30;
        rob_flush_ready = 1'b0;
        viol_info[0] = mk(2, 1'b0);
        viol_info[1] = mk(31, 1'b0);
        viol_valid = 2'b11;
        nxt();
        quiet();
        chk("s2_flush_tag", 64'(rob_flush_tag), 64'd31);
        rob_flush_ready = 1'b1;
        nxt();
        nxt();
        nxt();
        chk("s2_busy_done", 64'(busy), 64'd0);

        // pending slot: older kept, younger dropped
        rob_head_tag = 5'd0;
        rob_flush_ready = 1'b0;
        viol_info[0] = mk(10, 1'b0);
        viol_valid = 2'b01;
        nxt();
        viol_info[0] = mk(8, 1'b0);
        nxt();
        viol_info[0] = mk(12, 1'b0);
        nxt();
        quiet();
        chk("s3_flush_tag_held", 64'(rob_flush_tag), 64'd10);
        rob_flush_ready = 1'b1;
        nxt();
        chk("s3_redir_pc", 64'(if_redirect_pc), 64'h8000_0028);
        nxt();
        chk("s3_train_lpc", 64'(id_train_load_pc), 64'd10);
        nxt();
        chk("s3_flush_valid_pend", 64'(rob_flush_valid), 64'd1);
        chk("s3_flush_tag_pend", 64'(rob_flush_tag), 64'd8);
        nxt();
        nxt();
        nxt();
        chk("s3_busy_done", 64'(busy), 64'd0);

        // ext_flush kills held, then a younger ext_flush leaves it alone
        rob_flush_ready = 1'b0;
        viol_info[0] = mk(6, 1'b0);
        viol_valid = 2'b01;
        nxt();
        quiet();
        ext_flush = 1'b1;
        ext_flush_tag = 5'd4;
        rob_flush_ready = 1'b1;
        nxt();
        ext_flush = 1'b0;
        chk("s4_kill_busy", 64'(busy), 64'd0);
        chk("s4_kill_flush", 64'(rob_flush_valid), 64'd0);
        nxt();
        chk("s4_kill_no_redir", 64'(if_redirect_valid), 64'd0);
        rob_flush_ready = 1'b0;
        viol_info[0] = mk(6, 1'b0);
        viol_valid = 2'b01;
        nxt();
        quiet();
        ext_flush = 1'b1;
        ext_flush_tag = 5'd7;
        nxt();
        ext_flush = 1'b0;
        chk("s4_keep_flush", 64'(rob_flush_valid), 64'd1);
        chk("s4_keep_tag", 64'(rob_flush_tag), 64'd6);
        rob_flush_ready = 1'b1;
        nxt();
        nxt();
        nxt();

        // reset in REDIRECT
        viol_info[0] = mk(3, 1'b0);
        viol_valid = 2'b01;
        nxt();
        quiet();
        nxt();
        chk("s5_redir_before", 64'(if_redirect_valid), 64'd1);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        chk("s5_rst_redir", 64'(if_redirect_valid), 64'd0);
        chk("s5_rst_pc", 64'(if_redirect_pc), 64'd0);
        chk("s5_rst_busy", 64'(busy), 64'd0);
        nxt();
        chk("s5_no_train", 64'(id_train_valid), 64'd0);
        viol_info[0] = mk(9, 1'b0);
        viol_valid = 2'b01;
        nxt();
        quiet();
        chk("s5_after_tag", 64'(rob_flush_tag), 64'd9);
        nxt();
        nxt();
        nxt();
        chk("s5_after_busy", 64'(busy), 64'd0);

`ifdef FALCO_VIOLATION_STATS_EN
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        run_seq(1, 1'b0);
        run_seq(2, 1'b0);
        run_seq(3, 1'b0);
        run_seq(4, 1'b1);
        nxt();
        chk("s6_stat_ss", 64'(stat_storeset_cnt), 64'd3);
        chk("s6_stat_dev", 64'(stat_device_cnt), 64'd1);
`else
        run_seq(1, 1'b0);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < NP; p++) begin
                viol_valid[p] = ($urandom_range(0, 4) == 0);
                viol_info[p]  = rmk();
            end
            rob_flush_ready = 1'($urandom_range(0, 1));
            ext_flush       = ($urandom_range(0, 19) == 0);
            ext_flush_tag   = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) rob_head_tag = 5'($urandom_range(0, 31));
            nxt();
        end
        quiet();
        rst = 1'b0;
        nxt();
        nxt();

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
